// File: rtl/alu_muldiv.sv
// Execute-stage ALU with iterative RV32M mul/div; base ops, illegal opcodes and div special cases finish after one cycle, others spend XLEN cycles busy.
// Holds its result in DONE until out_ready; while busy in_ready is low and the upstream stage must hold its operation.
module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      operation,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic            busy
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_XOR    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] acc_q, lo_q, opnd_q, result_q;
    logic            neg_q, div_q, hi_q, illegal_q;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            md_op, div_op, illegal_op;
    logic            a_signed, b_signed, a_neg, b_neg, st_neg, st_hi;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign in_ready    = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept      = in_valid & in_ready;
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_BUSY);
    assign out_result  = result_q;
    assign out_illegal = illegal_q;
    assign shamt       = in_2[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (operation)
            OP_ADD:  base_res = in_1 + in_2;
            OP_SUB:  base_res = in_1 - in_2;
            OP_XOR:  base_res = in_1 ^ in_2;
            OP_OR:   base_res = in_1 | in_2;
            OP_AND:  base_res = in_1 & in_2;
            OP_SLL:  base_res = in_1 << shamt;
            OP_SRL:  base_res = in_1 >> shamt;
            OP_SRA:  base_res = $signed(in_1) >>> shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_1) < $signed(in_2)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, in_1 < in_2};
            default: base_res = '0;
        endcase
    end

    // Operand magnitudes and result sign for the iterative path.
    assign md_op      = (operation >= OP_MUL) && (operation <= OP_REMU);
    assign div_op     = md_op && (operation >= OP_DIV);
    assign illegal_op = (operation > OP_REMU);
    assign a_signed   = (operation == OP_MULH) || (operation == OP_MULHSU) ||
                        (operation == OP_DIV)  || (operation == OP_REM);
    assign b_signed   = (operation == OP_MULH) || (operation == OP_DIV) || (operation == OP_REM);
    assign a_neg      = a_signed & in_1[XLEN-1];
    assign b_neg      = b_signed & in_2[XLEN-1];
    assign a_mag      = a_neg ? -in_1 : in_1;
    assign b_mag      = b_neg ? -in_2 : in_2;
    assign st_neg     = (operation == OP_REM) ? a_neg : (a_neg ^ b_neg);
    assign st_hi      = (operation == OP_MULH) || (operation == OP_MULHSU) ||
                        (operation == OP_MULHU) || (operation == OP_REM) || (operation == OP_REMU);

    assign div_zero = div_op && (in_2 == '0);
    assign div_ovf  = ((operation == OP_DIV) || (operation == OP_REM)) &&
                      (in_1 == MIN_NEG) && (in_2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = ((operation == OP_DIV) || (operation == OP_DIVU)) ? '1 : in_1;
        end else if (div_ovf) begin
            special_res = (operation == OP_DIV) ? in_1 : '0;
        end
    end

    // Shift-add multiply keeps {acc,lo} as the running product; restoring divide
    // keeps the partial remainder in acc and shifts quotient bits into lo.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     r_shift, trial;
    logic              ge;
    logic [XLEN-1:0]   acc_d, lo_d, div_sel, div_f;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   iter_res;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        r_shift = {acc_q, lo_q[XLEN-1]};
        trial   = r_shift - {1'b0, opnd_q};
        ge      = ~trial[XLEN];
        if (div_q) begin
            acc_d = ge ? trial[XLEN-1:0] : r_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ge};
        end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {acc_d, lo_d};
        prod_f   = neg_q ? -prod : prod;
        div_sel  = hi_q ? acc_d : lo_d;
        div_f    = neg_q ? -div_sel : div_sel;
        iter_res = div_q ? div_f : (hi_q ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            div_q     <= 1'b0;
            hi_q      <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    cnt_q <= cnt_q + SHW'(1);
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    if (cnt_q == CNT_LAST) begin
                        result_q  <= iter_res;
                        illegal_q <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        illegal_q <= illegal_op;
                        if (md_op && !special) begin
                            state_q <= S_BUSY;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            lo_q    <= div_op ? a_mag : b_mag;
                            opnd_q  <= div_op ? b_mag : a_mag;
                            neg_q   <= st_neg;
                            div_q   <= div_op;
                            hi_q    <= st_hi;
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= special ? special_res : base_res;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed bench for alu_muldiv with a queue-based scoreboard and an independent monitor.
module tb_alu_muldiv;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          acc_edge;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  operation = 5'd0;
    logic [31:0] in_1 = '0;
    logic [31:0] in_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_illegal;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    exp_t sb[$];
    bit   rdy_force = 1'b1;
    bit   rdy_val   = 1'b0;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .in_1       (in_1),
        .in_2       (in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) out_ready = rdy_force ? rdy_val : ($urandom_range(3) != 0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules, using wide integers.
    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output bit iter);
        logic [63:0] p;
        longint      sa, sb2;
        int          sh;
        sh   = int'(b[4:0]);
        r    = '0;
        ill  = 1'b0;
        iter = 1'b0;
        p    = '0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a ^ b;
            3:  r = a | b;
            4:  r = a & b;
            5:  r = a << sh;
            6:  r = a >> sh;
            7:  r = $signed(a) >>> sh;
            8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  r = (a < b) ? 32'd1 : 32'd0;
            10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; iter = 1'b1; end
            11: begin
                sa = longint'($signed(a)); sb2 = longint'($signed(b));
                p = 64'(sa * sb2); r = p[63:32]; iter = 1'b1;
            end
            12: begin
                sa = longint'($signed(a)); sb2 = longint'({32'b0, b});
                p = 64'(sa * sb2); r = p[63:32]; iter = 1'b1;
            end
            13: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; iter = 1'b1; end
            14, 15, 16, 17: begin
                if (b == 32'd0) begin
                    r = (op == 14 || op == 15) ? 32'hFFFF_FFFF : a;
                end else if ((op == 14 || op == 16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (op == 14) ? a : 32'd0;
                end else begin
                    iter = 1'b1;
                    case (op)
                        14:      r = $signed(a) / $signed(b);
                        15:      r = a / b;
                        16:      r = $signed(a) % $signed(b);
                        default: r = a % b;
                    endcase
                end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic ill, input bit iter, output int waits);
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = op;
        in_1      = a;
        in_2      = b;
        #2;
        waits = 0;
        while (!in_ready && waits < 400) begin
            @(negedge clk);
            #2;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still low after %0d cycles, op %0d", waits, op);
        end else begin
            e.res      = r;
            e.ill      = ill;
            e.acc_edge = edges + 1;
            e.lat      = iter ? XLEN + 1 : 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 5'($urandom);
        in_1      = $urandom;
        in_2      = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: latency and value on first presentation, stability while stalled.
    initial begin : monitor
        bit          held;
        logic [31:0] held_res;
        logic        held_ill;
        int          busy_run;
        held     = 1'b0;
        held_res = '0;
        held_ill = 1'b0;
        busy_run = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held     = 1'b0;
                busy_run = 0;
                continue;
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_cycles", 64'(busy_run), 64'(XLEN));
                busy_run = 0;
            end
            if (out_valid) begin
                if (held) begin
                    chk("hold_result", out_result, held_res);
                    chk("hold_illegal", out_illegal, held_ill);
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h with nothing outstanding", out_result);
                end else begin
                    chk("latency", 64'(edges - sb[0].acc_edge + 1), 64'(sb[0].lat));
                    chk("result", out_result, sb[0].res);
                    chk("illegal", out_illegal, sb[0].ill);
                end
                held     = !out_ready;
                held_res = out_result;
                held_ill = out_illegal;
                if (out_ready && sb.size() != 0) void'(sb.pop_front());
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [4:0]  d_op  [15] = '{5'd0, 5'd7, 5'd8, 5'd9, 5'd13, 5'd11, 5'd10, 5'd14,
                                5'd16, 5'd15, 5'd17, 5'd14, 5'd17, 5'd14, 5'd20};
    logic [31:0] d_a   [15] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h1234_5678};
    logic [31:0] d_b   [15] = '{32'd1, 32'h24, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd3,
                                32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'd9};
    logic [31:0] d_res [15] = '{32'h0, 32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    bit          d_itr [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin : stimulus
        int          waits;
        logic [4:0]  op;
        logic [31:0] a, b, r;
        logic        ill;
        bit          iter;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_result", out_result, 32'd0);
        chk("reset_illegal", out_illegal, 1'b0);
        rst       = 1'b0;
        rdy_force = 1'b0;

        for (int i = 0; i < 15; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_res[i], (d_op[i] == 5'd20), d_itr[i], waits);
        end
        drain();

        // Stall in DONE, then release with a new op presented on the same edge.
        rdy_force = 1'b1;
        rdy_val   = 1'b0;
        issue(5'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, waits);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        rdy_val = 1'b1;
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, waits);
        chk("no_bubble_waits", 64'(waits), 64'd0);
        rdy_force = 1'b0;
        drain();

        // Reset in the middle of a DIVU drops it without a result.
        issue(5'd15, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b1, waits);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_result", out_result, 32'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(9) == 0) ? 5'($urandom_range(31, 18)) : 5'($urandom_range(17));
            a  = pick();
            b  = pick();
            model(int'(op), a, b, r, ill, iter);
            issue(op, a, b, r, ill, iter, waits);
            if ($urandom_range(4) == 0) repeat ($urandom_range(3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
